rx_frame_filter: RTL and testbench

Parametrised receive-side frame filter and buffer between `rx_receiver` and the display/host logic. It classifies each completed frame by CRC status and destination ID, with optional broadcast acceptance. Accepted frames (source ID plus payload) go into a DEPTH-entry FIFO, and the block keeps saturating per-class statistics counters. Compared with the single-frame ID check used so far, it adds buffering, broadcast, overflow handling and counters.

---
 rtl/rx_frame_filter.sv | 185 ++++++++++++++++++
 tb/tb_rx_frame_filter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_filter.sv
// rx_frame_filter
//
// Receive-side frame filter and buffer. Each completed frame (frm_valid pulse)
// is classified by CRC status and destination ID. Accepted frames (source ID +
// payload) are stored in a DEPTH-entry circular FIFO. Saturating per-class
// statistics counters and a sticky overflow flag track what was seen.
//
// Ports:
//   clk          single clock
//   rst_n        asynchronous active-low reset
//   my_id        local node ID, sampled on frm_valid
//   frm_valid    one-cycle pulse, frame completed
//   frm_dest     destination ID of the frame
//   frm_src      source ID of the frame
//   frm_payload  frame payload
//   frm_crc_err  CRC failure flag
//   pop          discard the head entry (ignored when empty)
//   byte_sel     selects a byte of the head payload for rd_byte
//   clr_stats    synchronous clear of counters, overflow and last_cls
//   rd_valid     FIFO not empty
//   rd_src       source ID of the head entry (0 when empty)
//   rd_byte      selected head payload byte (0 when empty)
//   level        number of stored entries
//   full         level == DEPTH
//   overflow     sticky: a frame was lost because the FIFO was full
//   last_cls     class of the most recent frame (0 ok, 1 CRC, 2 ID, 3 overflow)
//   cnt_ok/cnt_crc/cnt_id/cnt_ovf  saturating statistics counters

module rx_frame_filter #(
    parameter int ID_W      = 2,
    parameter int PAYLOAD_W = 128,
    parameter int DEPTH     = 4,
    parameter int BCAST_EN  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ID_W-1:0]                   my_id,
    input  logic                              frm_valid,
    input  logic [ID_W-1:0]                   frm_dest,
    input  logic [ID_W-1:0]                   frm_src,
    input  logic [PAYLOAD_W-1:0]              frm_payload,
    input  logic                              frm_crc_err,
    input  logic                              pop,
    input  logic [$clog2(PAYLOAD_W/8)-1:0]    byte_sel,
    input  logic                              clr_stats,
    output logic                              rd_valid,
    output logic [ID_W-1:0]                   rd_src,
    output logic [7:0]                        rd_byte,
    output logic [$clog2(DEPTH+1)-1:0]        level,
    output logic                              full,
    output logic                              overflow,
    output logic [1:0]                        last_cls,
    output logic [CNT_W-1:0]                  cnt_ok,
    output logic [CNT_W-1:0]                  cnt_crc,
    output logic [CNT_W-1:0]                  cnt_id,
    output logic [CNT_W-1:0]                  cnt_ovf
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH+1);
    localparam int BSEL_W = $clog2(PAYLOAD_W/8);

    localparam logic [1:0] CLS_OK  = 2'd0;
    localparam logic [1:0] CLS_CRC = 2'd1;
    localparam logic [1:0] CLS_ID  = 2'd2;
    localparam logic [1:0] CLS_OVF = 2'd3;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [ID_W-1:0]      src_mem [DEPTH];
    logic [PAYLOAD_W-1:0] pay_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic       is_bcast;
    logic       id_match;
    logic       do_pop;
    logic       do_push;
    logic [1:0] cls;

    assign rd_valid = (level != '0);
    assign full     = (level == LVL_W'(DEPTH));

    assign is_bcast = (BCAST_EN != 0) && (frm_dest == {ID_W{1'b1}});
    assign id_match = (frm_dest == my_id) || is_bcast;
    assign do_pop   = pop && rd_valid;

    // Classification by priority. A full FIFO with a same-cycle pop frees
    // the slot, so the frame is accepted rather than flagged as overflow.
    always_comb begin
        cls = CLS_OK;
        if (frm_crc_err) begin
            cls = CLS_CRC;
        end else if (!id_match) begin
            cls = CLS_ID;
        end else if (full && !pop) begin
            cls = CLS_OVF;
        end
    end

    assign do_push = frm_valid && (cls == CLS_OK);

    // Control state: pointers, level, statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            last_cls <= CLS_OK;
            cnt_ok   <= '0;
            cnt_crc  <= '0;
            cnt_id   <= '0;
            cnt_ovf  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end

            // Clear wins over a coinciding frame for counters and overflow.
            if (clr_stats) begin
                cnt_ok   <= '0;
                cnt_crc  <= '0;
                cnt_id   <= '0;
                cnt_ovf  <= '0;
                overflow <= 1'b0;
            end else if (frm_valid) begin
                unique case (cls)
                    CLS_OK:  cnt_ok  <= sat_inc(cnt_ok);
                    CLS_CRC: cnt_crc <= sat_inc(cnt_crc);
                    CLS_ID:  cnt_id  <= sat_inc(cnt_id);
                    default: begin
                        cnt_ovf  <= sat_inc(cnt_ovf);
                        overflow <= 1'b1;
                    end
                endcase
            end

            // A coinciding frame's class takes precedence over the clear.
            if (frm_valid) begin
                last_cls <= cls;
            end else if (clr_stats) begin
                last_cls <= CLS_OK;
            end
        end
    end

    // Storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            src_mem[wr_ptr] <= frm_src;
            pay_mem[wr_ptr] <= frm_payload;
        end
    end

    // Combinational readout of the head entry, forced to zero when empty.
    logic [PAYLOAD_W-1:0] head_pay;
    logic [BSEL_W+2:0]    bit_idx;

    assign head_pay = pay_mem[rd_ptr];
    assign bit_idx  = {byte_sel, 3'b000};

    always_comb begin
        rd_src  = '0;
        rd_byte = '0;
        if (rd_valid) begin
            rd_src  = src_mem[rd_ptr];
            rd_byte = head_pay[bit_idx +: 8];
        end
    end

endmodule

// File: tb/tb_rx_frame_filter.sv
module tb_rx_frame_filter;

    localparam int ID_W      = 2;
    localparam int PAYLOAD_W = 128;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 3;
    localparam int BSEL_W    = $clog2(PAYLOAD_W/8);
    localparam int LVL_W     = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [ID_W-1:0]      my_id;
    logic                 frm_valid;
    logic [ID_W-1:0]      frm_dest;
    logic [ID_W-1:0]      frm_src;
    logic [PAYLOAD_W-1:0] frm_payload;
    logic                 frm_crc_err;
    logic                 pop;
    logic [BSEL_W-1:0]    byte_sel;
    logic                 clr_stats;

    logic                 rd_valid;
    logic [ID_W-1:0]      rd_src;
    logic [7:0]           rd_byte;
    logic [LVL_W-1:0]     level;
    logic                 full;
    logic                 overflow;
    logic [1:0]           last_cls;
    logic [CNT_W-1:0]     cnt_ok, cnt_crc, cnt_id, cnt_ovf;

    // Second instance without broadcast acceptance
    logic                 nb_rd_valid;
    logic [ID_W-1:0]      nb_rd_src;
    logic [7:0]           nb_rd_byte;
    logic [LVL_W-1:0]     nb_level;
    logic                 nb_full;
    logic                 nb_overflow;
    logic [1:0]           nb_last_cls;
    logic [7:0]           nb_cnt_ok, nb_cnt_crc, nb_cnt_id, nb_cnt_ovf;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rx_frame_filter #(
        .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .BCAST_EN(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .my_id(my_id), .frm_valid(frm_valid),
        .frm_dest(frm_dest), .frm_src(frm_src), .frm_payload(frm_payload),
        .frm_crc_err(frm_crc_err), .pop(pop), .byte_sel(byte_sel), .clr_stats(clr_stats),
        .rd_valid(rd_valid), .rd_src(rd_src), .rd_byte(rd_byte), .level(level),
        .full(full), .overflow(overflow), .last_cls(last_cls),
        .cnt_ok(cnt_ok), .cnt_crc(cnt_crc), .cnt_id(cnt_id), .cnt_ovf(cnt_ovf)
    );

    rx_frame_filter #(
        .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .BCAST_EN(0), .CNT_W(8)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .my_id(my_id), .frm_valid(frm_valid),
        .frm_dest(frm_dest), .frm_src(frm_src), .frm_payload(frm_payload),
        .frm_crc_err(frm_crc_err), .pop(pop), .byte_sel(byte_sel), .clr_stats(clr_stats),
        .rd_valid(nb_rd_valid), .rd_src(nb_rd_src), .rd_byte(nb_rd_byte), .level(nb_level),
        .full(nb_full), .overflow(nb_overflow), .last_cls(nb_last_cls),
        .cnt_ok(nb_cnt_ok), .cnt_crc(nb_cnt_crc), .cnt_id(nb_cnt_id), .cnt_ovf(nb_cnt_ovf)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frm_valid   = 1'b0;
        frm_dest    = '0;
        frm_src     = '0;
        frm_payload = '0;
        frm_crc_err = 1'b0;
        pop         = 1'b0;
        clr_stats   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        byte_sel = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [ID_W-1:0] dest, input logic [ID_W-1:0] src,
                        input logic [PAYLOAD_W-1:0] pl, input logic crc, input logic p);
        frm_valid   = 1'b1;
        frm_dest    = dest;
        frm_src     = src;
        frm_payload = pl;
        frm_crc_err = crc;
        pop         = p;
        tick();
        idle_inputs();
    endtask

    task automatic pop_one();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        my_id = 2'd2;
        do_reset();
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b want 0", full); end
        vectors++; if ({rd_src, rd_byte} !== 10'h0) begin miscompares++; $display("FAIL reset_read: got %0h want 0", {rd_src, rd_byte}); end
        vectors++; if ({cnt_ok, cnt_crc, cnt_id, cnt_ovf, overflow, last_cls} !== 15'h0) begin
            miscompares++; $display("FAIL reset_stats: got %0h want 0", {cnt_ok, cnt_crc, cnt_id, cnt_ovf, overflow, last_cls}); end
    endtask

    task automatic test_basic();
        do_reset();
        my_id = 2'd2;
        send(2'd2, 2'd1, 128'h01, 1'b0, 1'b0);
        send(2'd2, 2'd2, 128'h02, 1'b0, 1'b0);
        send(2'd2, 2'd3, 128'h03, 1'b0, 1'b0);
        vectors++; if (level !== 3'd3) begin miscompares++; $display("FAIL basic_level: got %0d want 3", level); end
        vectors++; if (cnt_ok !== 3'd3) begin miscompares++; $display("FAIL basic_cnt_ok: got %0d want 3", cnt_ok); end
        vectors++; if (last_cls !== 2'd0) begin miscompares++; $display("FAIL basic_last_cls: got %0d want 0", last_cls); end
        byte_sel = '0;
        for (int i = 1; i <= 3; i++) begin
            vectors++; if (rd_valid !== 1'b1 || rd_byte !== 8'(i)) begin
                miscompares++; $display("FAIL basic_read%0d: got v=%0b byte=%0h want v=1 byte=%0h", i, rd_valid, rd_byte, i); end
            vectors++; if (rd_src !== 2'(i)) begin miscompares++; $display("FAIL basic_src%0d: got %0d want %0d", i, rd_src, i); end
            pop_one();
        end
        vectors++; if (rd_valid !== 1'b0 || level !== 3'd0 || rd_byte !== 8'h0) begin
            miscompares++; $display("FAIL basic_drained: got v=%0b lvl=%0d byte=%0h want 0 0 0", rd_valid, level, rd_byte); end
    endtask

    task automatic test_byte_sel();
        logic [PAYLOAD_W-1:0] pat;
        int sels [3];
        do_reset();
        my_id = 2'd2;
        pat = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        sels = '{0, 5, 15};
        send(2'd2, 2'd3, pat, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            byte_sel = BSEL_W'(sels[k]);
            #1;
            vectors++; if (rd_byte !== 8'(sels[k])) begin
                miscompares++; $display("FAIL byte_sel%0d: got %0h want %0h", sels[k], rd_byte, sels[k]); end
        end
        byte_sel = '0;
    endtask

    task automatic test_bcast();
        do_reset();
        my_id = 2'd1;
        send(2'd3, 2'd0, 128'hAA, 1'b0, 1'b0);
        vectors++; if (cnt_ok !== 3'd1 || level !== 3'd1 || last_cls !== 2'd0) begin
            miscompares++; $display("FAIL bcast_on: got ok=%0d lvl=%0d cls=%0d want 1 1 0", cnt_ok, level, last_cls); end
        vectors++; if (nb_cnt_id !== 8'd1 || nb_last_cls !== 2'd2 || nb_level !== 3'd0 || nb_cnt_ok !== 8'd0) begin
            miscompares++; $display("FAIL bcast_off: got id=%0d cls=%0d lvl=%0d ok=%0d want 1 2 0 0", nb_cnt_id, nb_last_cls, nb_level, nb_cnt_ok); end
        send(2'd2, 2'd0, 128'hBB, 1'b0, 1'b0);
        vectors++; if (cnt_id !== 3'd1 || last_cls !== 2'd2 || level !== 3'd1) begin
            miscompares++; $display("FAIL id_mismatch: got id=%0d cls=%0d lvl=%0d want 1 2 1", cnt_id, last_cls, level); end
    endtask

    task automatic test_crc();
        do_reset();
        my_id = 2'd2;
        send(2'd2, 2'd1, 128'h11, 1'b1, 1'b0);
        vectors++; if (cnt_crc !== 3'd1 || level !== 3'd0 || last_cls !== 2'd1 || cnt_ok !== 3'd0) begin
            miscompares++; $display("FAIL crc_drop: got crc=%0d lvl=%0d cls=%0d ok=%0d want 1 0 1 0", cnt_crc, level, last_cls, cnt_ok); end
        // CRC has priority over an ID mismatch
        send(2'd0, 2'd1, 128'h12, 1'b1, 1'b0);
        vectors++; if (cnt_crc !== 3'd2 || cnt_id !== 3'd0 || last_cls !== 2'd1) begin
            miscompares++; $display("FAIL crc_priority: got crc=%0d id=%0d cls=%0d want 2 0 1", cnt_crc, cnt_id, last_cls); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [4];
        do_reset();
        my_id = 2'd2;
        // Back-to-back fill: frm_valid held high for DEPTH cycles
        frm_valid = 1'b1;
        frm_dest  = 2'd2;
        for (int i = 0; i < DEPTH; i++) begin
            frm_src     = 2'(i);
            frm_payload = 128'(8'h10 + i);
            tick();
        end
        idle_inputs();
        vectors++; if (level !== 3'd4 || full !== 1'b1 || cnt_ok !== 3'd4) begin
            miscompares++; $display("FAIL fill: got lvl=%0d full=%0b ok=%0d want 4 1 4", level, full, cnt_ok); end
        send(2'd2, 2'd1, 128'h99, 1'b0, 1'b0);
        vectors++; if (cnt_ovf !== 3'd1 || overflow !== 1'b1 || last_cls !== 2'd3 || level !== 3'd4) begin
            miscompares++; $display("FAIL ovf: got ovf=%0d flag=%0b cls=%0d lvl=%0d want 1 1 3 4", cnt_ovf, overflow, last_cls, level); end
        vectors++; if (rd_byte !== 8'h10 || rd_src !== 2'd0) begin
            miscompares++; $display("FAIL ovf_head: got byte=%0h src=%0d want 10 0", rd_byte, rd_src); end
        send(2'd2, 2'd1, 128'h55, 1'b0, 1'b1);
        vectors++; if (level !== 3'd4 || cnt_ovf !== 3'd1 || cnt_ok !== 3'd5 || last_cls !== 2'd0) begin
            miscompares++; $display("FAIL full_push_pop: got lvl=%0d ovf=%0d ok=%0d cls=%0d want 4 1 5 0", level, cnt_ovf, cnt_ok, last_cls); end
        exp_b = '{8'h11, 8'h12, 8'h13, 8'h55};
        for (int i = 0; i < 4; i++) begin
            vectors++; if (rd_byte !== exp_b[i]) begin
                miscompares++; $display("FAIL wrap_read%0d: got %0h want %0h", i, rd_byte, exp_b[i]); end
            pop_one();
        end
        pop_one();
        vectors++; if (level !== 3'd0 || rd_valid !== 1'b0) begin
            miscompares++; $display("FAIL pop_empty: got lvl=%0d v=%0b want 0 0", level, rd_valid); end
        send(2'd2, 2'd3, 128'h66, 1'b0, 1'b1);
        vectors++; if (level !== 3'd1 || rd_byte !== 8'h66 || rd_src !== 2'd3) begin
            miscompares++; $display("FAIL empty_push_pop: got lvl=%0d byte=%0h src=%0d want 1 66 3", level, rd_byte, rd_src); end
    endtask

    // Continues from test_overflow state: level 1, overflow set, cnt_ok 6
    task automatic test_saturation_clear();
        frm_valid   = 1'b1;
        frm_dest    = 2'd2;
        frm_crc_err = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        idle_inputs();
        vectors++; if (cnt_crc !== 3'd7 || cnt_ok !== 3'd6 || level !== 3'd1) begin
            miscompares++; $display("FAIL saturate: got crc=%0d ok=%0d lvl=%0d want 7 6 1", cnt_crc, cnt_ok, level); end
        clr_stats = 1'b1;
        send(2'd2, 2'd0, 128'h77, 1'b0, 1'b0);
        vectors++; if ({cnt_ok, cnt_crc, cnt_id, cnt_ovf} !== 12'h0 || overflow !== 1'b0) begin
            miscompares++; $display("FAIL clr_with_frame: got cnts=%0h ovf=%0b want 0 0", {cnt_ok, cnt_crc, cnt_id, cnt_ovf}, overflow); end
        vectors++; if (level !== 3'd2 || last_cls !== 2'd0) begin
            miscompares++; $display("FAIL clr_frame_stored: got lvl=%0d cls=%0d want 2 0", level, last_cls); end
        send(2'd2, 2'd0, 128'h78, 1'b1, 1'b0);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        vectors++; if (last_cls !== 2'd0 || cnt_crc !== 3'd0 || level !== 3'd2 || rd_byte !== 8'h66) begin
            miscompares++; $display("FAIL clr_alone: got cls=%0d crc=%0d lvl=%0d head=%0h want 0 0 2 66", last_cls, cnt_crc, level, rd_byte); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        my_id = 2'd0;
        send(2'd0, 2'd1, 128'h31, 1'b0, 1'b0);
        send(2'd0, 2'd2, 128'h32, 1'b0, 1'b0);
        send(2'd0, 2'd3, 128'h33, 1'b0, 1'b1);
        vectors++; if (level !== 3'd2 || rd_byte !== 8'h32 || cnt_ok !== 3'd3) begin
            miscompares++; $display("FAIL mid_push_pop: got lvl=%0d head=%0h ok=%0d want 2 32 3", level, rd_byte, cnt_ok); end
    endtask

    task automatic test_async_reset();
        do_reset();
        my_id = 2'd2;
        byte_sel = 4'd0;
        send(2'd2, 2'd1, 128'h41, 1'b0, 1'b0);
        send(2'd2, 2'd1, 128'h42, 1'b0, 1'b0);
        frm_valid = 1'b1; frm_dest = 2'd2; frm_src = 2'd2; frm_payload = 128'h43;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if ({level, rd_valid, full, rd_src, rd_byte} !== 15'h0) begin
            miscompares++; $display("FAIL async_rst_fifo: got %0h want 0", {level, rd_valid, full, rd_src, rd_byte}); end
        vectors++; if ({cnt_ok, cnt_crc, cnt_id, cnt_ovf, overflow, last_cls} !== 15'h0) begin
            miscompares++; $display("FAIL async_rst_stats: got %0h want 0", {cnt_ok, cnt_crc, cnt_id, cnt_ovf, overflow, last_cls}); end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        pop_one();
        vectors++; if (level !== 3'd0 || rd_valid !== 1'b0) begin
            miscompares++; $display("FAIL post_rst_pop: got lvl=%0d v=%0b want 0 0", level, rd_valid); end
        send(2'd2, 2'd1, 128'hAB, 1'b0, 1'b0);
        vectors++; if (level !== 3'd1 || rd_byte !== 8'hAB || rd_src !== 2'd1) begin
            miscompares++; $display("FAIL post_rst_head: got lvl=%0d byte=%0h src=%0d want 1 ab 1", level, rd_byte, rd_src); end
    endtask

    initial begin
        rst_n = 1'b0;
        my_id = '0;
        byte_sel = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_byte_sel();
        test_bcast();
        test_crc();
        test_overflow();
        test_saturation_clear();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
